// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, default sizing and the address width.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_START = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam int unsigned DEF_MAX_WORDS   = 1024;
   localparam int unsigned DEF_START_WIDTH = 1;
   localparam int unsigned ADDR_W          = 16;

   // One extra bit so the pointer can reach MAX_WORDS
   // itself (65536 words) and flag a full memory.
   localparam int unsigned CNT_W = ADDR_W + 1;

endpackage

// File: rtl/imem_wr_counter.sv
// Write pointer / word counter for the loader.
// Ports: clk, rst (async, active-low), i_clr, i_inc -> o_cnt, o_full.
module imem_wr_counter
   import imem_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_full
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_full;

   assign w_full = (r_cnt == CNT_W'(MAX_WORDS));

   // Saturates at MAX_WORDS so the address never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_full) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_full = w_full;

endmodule

// File: rtl/imem_loader.sv
// Streams host words into the CPU instruction memory, then pulses start.
// Ports: host side (load_req, host_*), imem write (InstrIn, MEM_Addr,
// I_MEM_Write_Enable), status (start, busy, word_count, overflow).
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS   = DEF_MAX_WORDS,
   parameter int unsigned START_WIDTH = DEF_START_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_req,
   input  logic        host_valid,
   input  logic [31:0] host_data,
   input  logic        host_last,
   output logic        host_ready,
   output logic [31:0] InstrIn,
   output logic        I_MEM_Write_Enable,
   output logic [15:0] MEM_Addr,
   output logic        start,
   output logic        busy,
   output logic [15:0] word_count,
   output logic        overflow
);

   state_t r_state;
   state_t w_next;

   logic [CNT_W-1:0] w_ptr;
   logic             w_full;
   logic             w_hs;
   logic             w_go;
   logic             w_last_word;
   logic             w_start_done;

   logic [3:0]  r_scnt;
   logic        r_we;
   logic        r_start;
   logic        r_ovf;
   logic [31:0] r_instr;
   logic [15:0] r_addr;

   imem_wr_counter #(
      .MAX_WORDS(MAX_WORDS)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_go),
      .i_inc (w_hs),
      .o_cnt (w_ptr),
      .o_full(w_full)
   );

   // Ready depends only on registered state, never on host_valid.
   assign host_ready   = (r_state == ST_LOAD) && !w_full;
   assign busy         = (r_state == ST_LOAD) ||
                         (r_state == ST_START);
   assign w_hs         = host_valid && host_ready;
   assign w_last_word  = (w_ptr == CNT_W'(MAX_WORDS - 1));
   assign w_start_done = (r_scnt == 4'(START_WIDTH - 1));

   always_comb begin
      w_next = r_state;
      w_go   = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_RUN: begin
            if (load_req) begin
               w_next = ST_LOAD;
               w_go   = 1'b1;
            end
         end
         ST_LOAD: begin
            // Full memory ends the load even without host_last.
            if (w_hs && (host_last || w_last_word)) begin
               w_next = ST_START;
            end
         end
         ST_START: begin
            if (w_start_done) begin
               w_next = ST_RUN;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we    <= 1'b0;
         r_start <= 1'b0;
         r_ovf   <= 1'b0;
         r_scnt  <= '0;
         r_instr <= '0;
         r_addr  <= '0;
      end else begin
         r_we <= w_hs;
         if (w_hs) begin
            r_instr <= host_data;
            r_addr  <= w_ptr[ADDR_W-1:0];
         end
         // Registered copy of next state: high exactly while in START.
         r_start <= (w_next == ST_START);
         if (r_state == ST_START && !w_start_done) begin
            r_scnt <= r_scnt + 4'd1;
         end else begin
            r_scnt <= '0;
         end
         if (w_go) begin
            r_ovf <= 1'b0;
         end else if (host_valid && w_full && busy) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign InstrIn            = r_instr;
   assign MEM_Addr           = r_addr;
   assign I_MEM_Write_Enable = r_we;
   assign start              = r_start;
   assign word_count         = w_ptr[ADDR_W-1:0];
   assign overflow           = r_ovf;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, randomized loads
// against a transaction-level model, and reset/overflow sequences.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_req = 1'b0;
   logic        host_valid = 1'b0;
   logic        host_last = 1'b0;
   logic [31:0] host_data = '0;

   logic        m_ready, m_we, m_start, m_busy, m_ovf;
   logic [31:0] m_instr;
   logic [15:0] m_addr, m_wc;
   logic        s_ready, s_we, s_start, s_busy, s_ovf;
   logic [31:0] s_instr;
   logic [15:0] s_addr, s_wc;

   always #5 clk = ~clk;

   imem_loader #(.MAX_WORDS(1024), .START_WIDTH(1)) u_main (
      .clk(clk), .rst(rst), .load_req(load_req),
      .host_valid(host_valid), .host_data(host_data),
      .host_last(host_last), .host_ready(m_ready),
      .InstrIn(m_instr), .I_MEM_Write_Enable(m_we),
      .MEM_Addr(m_addr), .start(m_start), .busy(m_busy),
      .word_count(m_wc), .overflow(m_ovf)
   );

   imem_loader #(.MAX_WORDS(4), .START_WIDTH(3)) u_small (
      .clk(clk), .rst(rst), .load_req(load_req),
      .host_valid(host_valid), .host_data(host_data),
      .host_last(host_last), .host_ready(s_ready),
      .InstrIn(s_instr), .I_MEM_Write_Enable(s_we),
      .MEM_Addr(s_addr), .start(s_start), .busy(s_busy),
      .word_count(s_wc), .overflow(s_ovf)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Observed write transactions and start pulse lengths per DUT.
   logic [15:0] m_wa[$], s_wa[$];
   logic [31:0] m_wd[$], s_wd[$];
   int          m_sp[$], s_sp[$];
   int          m_run = 0, s_run = 0;

   always @(negedge clk) begin
      if (m_we === 1'b1) begin
         m_wa.push_back(m_addr);
         m_wd.push_back(m_instr);
      end
      if (m_start === 1'b1) begin
         m_run++;
         chk("m_start_busy", 32'(m_busy), 32'd1);
      end else if (m_run > 0) begin
         m_sp.push_back(m_run);
         m_run = 0;
      end
      if (s_we === 1'b1) begin
         s_wa.push_back(s_addr);
         s_wd.push_back(s_instr);
      end
      if (s_start === 1'b1) begin
         s_run++;
         chk("s_start_busy", 32'(s_busy), 32'd1);
      end else if (s_run > 0) begin
         s_sp.push_back(s_run);
         s_run = 0;
      end
   end

   task automatic clear_mon();
      m_wa.delete(); m_wd.delete(); m_sp.delete();
      s_wa.delete(); s_wd.delete(); s_sp.delete();
   endtask

   typedef struct {
      logic        ld, v, l;
      logic [31:0] d;
      logic        rdy, we;
      logic [15:0] addr;
      logic [31:0] instr;
      logic        st, bsy;
      logic [15:0] wc;
   } vec_t;

   function automatic vec_t mk(
      input logic ld, input logic v, input logic l,
      input logic [31:0] d, input logic rdy, input logic we,
      input logic [15:0] a, input logic [31:0] ins,
      input logic st, input logic b, input logic [15:0] wc);
      vec_t r;
      r.ld = ld; r.v = v; r.l = l; r.d = d;
      r.rdy = rdy; r.we = we; r.addr = a; r.instr = ins;
      r.st = st; r.bsy = b; r.wc = wc;
      return r;
   endfunction

   logic [31:0] words[$];

   task automatic chk_zero(input bit s, input string t);
      chk({t, "_ready"}, 32'(s ? s_ready : m_ready), 32'd0);
      chk({t, "_we"},    32'(s ? s_we : m_we), 32'd0);
      chk({t, "_addr"},  32'(s ? s_addr : m_addr), 32'd0);
      chk({t, "_instr"}, s ? s_instr : m_instr, 32'd0);
      chk({t, "_start"}, 32'(s ? s_start : m_start), 32'd0);
      chk({t, "_busy"},  32'(s ? s_busy : m_busy), 32'd0);
      chk({t, "_wc"},    32'(s ? s_wc : m_wc), 32'd0);
      chk({t, "_ovf"},   32'(s ? s_ovf : m_ovf), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      load_req = 1'b0;
      host_valid = 1'b0;
      host_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Host: offers words[i] (valid optionally random) until n accepted.
   task automatic run_load(input int n, input bit rnd, input bit gs);
      int  i = 0;
      int  cyc = 0;
      bit  hs;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      while (i < n && cyc < 400) begin
         host_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         host_data  = words[i];
         host_last  = (i == n - 1);
         load_req   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         hs = host_valid && (gs ? s_ready : m_ready);
         @(posedge clk); #1;
         if (hs) i++;
         cyc++;
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      load_req   = 1'b0;
      n_checks++;
      if (i != n) begin
         n_errors++;
         $display("FAIL load_timeout: accepted %0d expected %0d", i, n);
      end
   endtask

   task automatic wait_idle(input bit m, input bit s);
      int cyc = 0;
      bit done = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         done = (!m || m_busy === 1'b0) && (!s || s_busy === 1'b0);
         cyc++;
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL idle_timeout: busy m=%b s=%b expected 0",
                  m_busy, s_busy);
      end
      @(posedge clk); #1;
   endtask

   // Model: n words land at addresses 0..n-1 in order, one start
   // pulse of sw cycles, then RUN with word_count = n.
   task automatic verify(input bit s, input int n, input int sw,
                         input logic ovf, input string t);
      logic [15:0] wa[$];
      logic [31:0] wd[$];
      int          sp[$];
      if (s) begin
         wa = s_wa; wd = s_wd; sp = s_sp;
      end else begin
         wa = m_wa; wd = m_wd; sp = m_sp;
      end
      chk({t, "_nwrites"}, 32'(wa.size()), 32'(n));
      for (int k = 0; k < n && k < wa.size(); k++) begin
         chk($sformatf("%s_addr%0d", t, k), 32'(wa[k]), 32'(k));
         chk($sformatf("%s_data%0d", t, k), wd[k], words[k]);
      end
      chk({t, "_npulses"}, 32'(sp.size()), 32'd1);
      if (sp.size() > 0) chk({t, "_pulselen"}, 32'(sp[0]), 32'(sw));
      chk({t, "_wc"},    32'(s ? s_wc : m_wc), 32'(n));
      chk({t, "_ovf"},   32'(s ? s_ovf : m_ovf), 32'(ovf));
      chk({t, "_busy"},  32'(s ? s_busy : m_busy), 32'd0);
      chk({t, "_ready"}, 32'(s ? s_ready : m_ready), 32'd0);
      chk({t, "_start"}, 32'(s ? s_start : m_start), 32'd0);
   endtask

   initial begin
      vec_t tbl[11];
      int   n;
      int   k;
      bit   hs;

      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[11];
      int   n;
      int   k;
      bit   hs;

      tbl[0]  = mk(1,0,0,32'h0,        0,0,16'd0,32'h0,        0,0,16'd0);
      tbl[1]  = mk(0,1,0,32'h11111111, 1,0,16'd0,32'h0,        0,1,16'd0);
      tbl[2]  = mk(0,1,0,32'h22222222, 1,1,16'd0,32'h11111111, 0,1,16'd1);
      tbl[3]  = mk(0,1,1,32'h33333333, 1,1,16'd1,32'h22222222, 0,1,16'd2);
      tbl[4]  = mk(1,0,0,32'h0,        0,1,16'd2,32'h33333333, 1,1,16'd3);
      tbl[5]  = mk(0,0,0,32'h0,        0,0,16'd2,32'h33333333, 0,0,16'd3);
      tbl[6]  = mk(0,1,1,32'hDEADBEEF, 0,0,16'd2,32'h33333333, 0,0,16'd3);
      tbl[7]  = mk(1,0,0,32'h0,        0,0,16'd2,32'h33333333, 0,0,16'd3);
      tbl[8]  = mk(1,1,1,32'hDEADBEEF, 1,0,16'd2,32'h33333333, 0,1,16'd0);
      tbl[9]  = mk(0,0,0,32'h0,        0,1,16'd0,32'hDEADBEEF, 1,1,16'd1);
      tbl[10] = mk(0,0,0,32'h0,        0,0,16'd0,32'hDEADBEEF, 0,0,16'd1);

      // Reset dominates active host inputs.
      load_req   = 1'b1;
      host_valid = 1'b1;
      host_data  = 32'hA5A5A5A5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero(1'b0, "rst_m");
      chk_zero(1'b1, "rst_s");
      load_req   = 1'b0;
      host_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      // Cycle table: 3-word load, reload of 1 word from RUN.
      for (int i = 0; i < 11; i++) begin
         load_req   = tbl[i].ld;
         host_valid = tbl[i].v;
         host_last  = tbl[i].l;
         host_data  = tbl[i].d;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), 32'(m_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_we", i), 32'(m_we), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_addr", i), 32'(m_addr), 32'(tbl[i].addr));
         chk($sformatf("tbl%0d_instr", i), m_instr, tbl[i].instr);
         chk($sformatf("tbl%0d_start", i), 32'(m_start), 32'(tbl[i].st));
         chk($sformatf("tbl%0d_busy", i), 32'(m_busy), 32'(tbl[i].bsy));
         chk($sformatf("tbl%0d_wc", i), 32'(m_wc), 32'(tbl[i].wc));
         chk($sformatf("tbl%0d_ovf", i), 32'(m_ovf), 32'd0);
         @(posedge clk); #1;
      end
      load_req   = 1'b0;
      host_valid = 1'b0;
      host_last  = 1'b0;

      // Random loads, random valid gaps and stray load_req.
      do_reset();
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 4);
         words.delete();
         for (int j = 0; j < n; j++) words.push_back($urandom);
         clear_mon();
         run_load(n, 1'b1, 1'b0);
         wait_idle(1'b1, 1'b1);
         verify(1'b0, n, 1, 1'b0, $sformatf("rnd%0d_m", it));
         verify(1'b1, n, 3, 1'b0, $sformatf("rnd%0d_s", it));
      end

      // Five words with random valid gaps.
      words.delete();
      for (int j = 0; j < 5; j++) words.push_back($urandom);
      clear_mon();
      run_load(5, 1'b1, 1'b0);
      wait_idle(1'b1, 1'b0);
      verify(1'b0, 5, 1, 1'b0, "five_m");

      // Small memory: six words offered, no last.
      do_reset();
      words.delete();
      for (int j = 0; j < 6; j++) words.push_back($urandom);
      clear_mon();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         host_valid = 1'b1;
         host_data  = words[k];
         host_last  = 1'b0;
         @(negedge clk);
         hs = s_ready;
         @(posedge clk); #1;
         if (hs && k < 5) k++;
      end
      host_valid = 1'b0;
      wait_idle(1'b0, 1'b1);
      verify(1'b1, 4, 3, 1'b1, "ovf_s");

      // Reload clears the sticky overflow.
      words.delete();
      words.push_back(32'hC0FFEE01);
      clear_mon();
      run_load(1, 1'b0, 1'b1);
      chk("ovf_cleared", 32'(s_ovf), 32'd0);
      wait_idle(1'b0, 1'b1);
      verify(1'b1, 1, 3, 1'b0, "reload_s");

      // Reset right after the second handshake of a 4-word load.
      do_reset();
      words.delete();
      for (int j = 0; j < 4; j++) words.push_back($urandom);
      clear_mon();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req   = 1'b0;
      host_valid = 1'b1;
      host_data  = words[0];
      @(posedge clk); #1;
      host_data = words[1];
      @(posedge clk); #1;
      rst = 1'b0;
      host_data = words[2];
      #1;
      chk_zero(1'b0, "abort_m");
      chk_zero(1'b1, "abort_s");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("post_ready%0d", c), 32'(m_ready), 32'd0);
         chk($sformatf("post_busy%0d", c), 32'(m_busy), 32'd0);
         @(posedge clk); #1;
      end
      host_valid = 1'b0;
      chk("abort_nwrites", 32'(m_wa.size()), 32'd1);
      if (m_wa.size() > 0) chk("abort_addr0", 32'(m_wa[0]), 32'd0);
      chk("abort_npulses", 32'(m_sp.size()), 32'd0);
      chk("abort_s_npulses", 32'(s_sp.size()), 32'd0);

      words.delete();
      words.push_back($urandom);
      clear_mon();
      run_load(1, 1'b0, 1'b0);
      wait_idle(1'b1, 1'b1);
      verify(1'b0, 1, 1, 1'b0, "after_m");
      verify(1'b1, 1, 3, 1'b0, "after_s");

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
